pg_domain_controller: RTL
=========================

// Module: pg_domain_controller
// PURPOSE
//  Power-gating sequencer for one gateable core domain (e.g. a lane-group of a
//  scalable structure). Drives the clampEn of that domain's PGIsolationCell
//  instances, the header power-switch enable and the domain-local reset, in a
//  safe order: isolate -> reset -> switch off; switch on -> power-good ->
//  reset hold -> de-isolate. Sits beside the domain; the core power manager
//  issues requests to it.
// PARAMETERS
//  ISO_SETUP_CYCLES  4    cycles clampEn held before switch-off (>=1)
//  RST_HOLD_CYCLES   8    cycles domainReset held after power-good (>=1)
//  PWR_TIMEOUT       64   max cycles waiting for pwrGood to change (>=1)
//  CNT_W    $clog2(max of above + 1)   internal counter width
// PORTS
//  clk          in   1  core clock
//  reset        in   1  synchronous, active-low reset
//  pwrDownReq   in   1  1-cycle pulse: request domain power-down
//  pwrUpReq     in   1  1-cycle pulse: request domain power-up
//  pwrGood      in   1  switch status from power network (1 = rail up)
//  clampEn      out  1  to PGIsolationCell.clampEn (1 = outputs clamped)
//  pwrSwitchEn  out  1  header switch enable (1 = domain powered)
//  domainReset  out  1  active-high reset into gated domain
//  domainOn     out  1  1 only in ON (domain usable, unclamped)
//  busy         out  1  1 in any transitional state
//  pwrError     out  1  sticky timeout flag
// BEHAVIOUR
//  All outputs registered; pure function of state except pwrError.
//  States / outputs (clampEn, pwrSwitchEn, domainReset):
//   ON       0,1,0   pwrDownReq -> ISO (count=0)
//   ISO      1,1,0   after ISO_SETUP_CYCLES cycles -> PWR_OFF
//   PWR_OFF  1,0,1   pwrGood==0 -> OFF; count==PWR_TIMEOUT -> OFF, pwrError=1
//   OFF      1,0,1   pwrUpReq -> PWR_ON (count=0)
//   PWR_ON   1,1,1   pwrGood==1 -> RST_HOLD; timeout -> OFF, pwrError=1
//   RST_HOLD 1,1,1   after RST_HOLD_CYCLES cycles -> DEISO
//   DEISO    1,1,0   exactly 1 cycle (reset released while still clamped) -> ON
//  Reset (reset==0 at clk edge): state=PWR_ON, count=0, pwrError=0; outputs
//   clampEn=1, pwrSwitchEn=1, domainReset=1, domainOn=0, busy=1. Domain thus
//   powers up by default; reset mid-sequence aborts to this state.
//  Latency: pwrDownReq in ON -> clampEn=1 next cycle; pwrSwitchEn=0 exactly
//   ISO_SETUP_CYCLES+1 cycles after request. Power-up with pwrGood already 1:
//   pwrUpReq -> domainOn=1 after 1+1+RST_HOLD_CYCLES+1 cycles.
//  Requests accepted only in ON (down) / OFF (up); ignored in all other states
//   and never queued. pwrUpReq in ON, pwrDownReq in OFF: ignored.
//  Both requests same cycle: only the one valid for current state acts.
//  Counter resets to 0 on every state entry; saturates, never wraps.
//  pwrError: set on timeout, cleared on next accepted request.
//  Invariant: clampEn==0 implies pwrSwitchEn==1 and domainReset==0.
//  busy = !(state==ON || state==OFF).
// TESTING
//  T1 reset low 2 cycles, pwrGood=1 -> clamp=1,sw=1,rst=1; RST_HOLD 8 cyc,
//     DEISO 1 cyc, domainOn=1 at cycle 11 after reset release.
//  T2 in ON pulse pwrDownReq -> clampEn=1 next cyc; sw=0 5 cyc later; drop
//     pwrGood 3 cyc after -> OFF, busy=0, pwrError=0.
//  T3 in OFF pulse pwrUpReq, hold pwrGood=0 -> after 64 cyc state OFF, sw=0,
//     pwrError=1; next pwrUpReq with pwrGood=1 clears pwrError, reaches ON.
//  T4 pulse pwrUpReq/pwrDownReq during ISO/RST_HOLD -> no effect on sequence;
//     both pulsed together in ON -> power-down only.
//  T5 assert reset mid-ISO and mid-PWR_OFF -> next cycle reset outputs exactly.
//  T6 random requests/pwrGood 10k cycles -> clamp invariant never violated.

Source files
------------

// File: rtl/pg_domain_controller.sv
// Power-gating sequencer for one gateable domain. Orders clamp, header switch
// and domain reset so the domain is isolated before power drops and stays
// clamped until its reset has been released after power returns.
module pg_domain_controller #(
  parameter int unsigned ISO_SETUP_CYCLES = 4,
  parameter int unsigned RST_HOLD_CYCLES  = 8,
  parameter int unsigned PWR_TIMEOUT      = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic pwrDownReq,
  input  logic pwrUpReq,
  input  logic pwrGood,
  output logic clampEn,
  output logic pwrSwitchEn,
  output logic domainReset,
  output logic domainOn,
  output logic busy,
  output logic pwrError
);

  localparam int unsigned MaxA = (ISO_SETUP_CYCLES > RST_HOLD_CYCLES) ?
                                 ISO_SETUP_CYCLES : RST_HOLD_CYCLES;
  localparam int unsigned MaxCycles = (MaxA > PWR_TIMEOUT) ? MaxA : PWR_TIMEOUT;
  localparam int unsigned CNT_W = $clog2(MaxCycles + 1);

  // Terminal counts: each timed state lasts exactly its parameter in cycles.
  localparam logic [CNT_W-1:0] IsoLast     = CNT_W'(ISO_SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] RstLast     = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(PWR_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntMax      = '1;

  typedef enum logic [2:0] {
    StOn, StIso, StPwrOff, StOff, StPwrOn, StRstHold, StDeiso
  } state_e;

  state_e           stateQ, stateD;
  logic [CNT_W-1:0] cntQ, cntD;
  logic             errQ, errD;
  logic             clampQ, clampD;
  logic             swQ, swD;
  logic             rstQ, rstD;
  logic             onQ, onD;
  logic             busyQ, busyD;

  // Next-state, timeout/error flag and per-state counter.
  always_comb begin
    stateD = stateQ;
    errD   = errQ;
    unique case (stateQ)
      StOn: begin
        if (pwrDownReq) begin
          stateD = StIso;
          errD   = 1'b0;
        end
      end
      StIso: begin
        if (cntQ == IsoLast) stateD = StPwrOff;
      end
      StPwrOff: begin
        if (!pwrGood) begin
          stateD = StOff;
        end else if (cntQ == TimeoutLast) begin
          stateD = StOff;
          errD   = 1'b1;
        end
      end
      StOff: begin
        if (pwrUpReq) begin
          stateD = StPwrOn;
          errD   = 1'b0;
        end
      end
      StPwrOn: begin
        if (pwrGood) begin
          stateD = StRstHold;
        end else if (cntQ == TimeoutLast) begin
          stateD = StOff;
          errD   = 1'b1;
        end
      end
      StRstHold: begin
        if (cntQ == RstLast) stateD = StDeiso;
      end
      StDeiso: stateD = StOn;
      default: stateD = StPwrOn;
    endcase
    // Restart on every state entry; saturate instead of wrapping.
    if (stateD != stateQ) begin
      cntD = '0;
    end else if (cntQ == CntMax) begin
      cntD = cntQ;
    end else begin
      cntD = cntQ + 1'b1;
    end
  end

  // Output decode from the next state so outputs are flops aligned with state.
  always_comb begin
    clampD = 1'b1;
    swD    = 1'b1;
    rstD   = 1'b0;
    unique case (stateD)
      StOn:      clampD = 1'b0;
      StIso:     ;
      StPwrOff:  begin swD = 1'b0; rstD = 1'b1; end
      StOff:     begin swD = 1'b0; rstD = 1'b1; end
      StPwrOn:   rstD = 1'b1;
      StRstHold: rstD = 1'b1;
      StDeiso:   ;
      default:   rstD = 1'b1;
    endcase
    onD   = (stateD == StOn);
    busyD = !((stateD == StOn) || (stateD == StOff));
  end

  // State, counter and output registers; reset aborts into power-up.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stateQ <= StPwrOn;
      cntQ   <= '0;
      errQ   <= 1'b0;
      clampQ <= 1'b1;
      swQ    <= 1'b1;
      rstQ   <= 1'b1;
      onQ    <= 1'b0;
      busyQ  <= 1'b1;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      errQ   <= errD;
      clampQ <= clampD;
      swQ    <= swD;
      rstQ   <= rstD;
      onQ    <= onD;
      busyQ  <= busyD;
    end
  end

  assign clampEn     = clampQ;
  assign pwrSwitchEn = swQ;
  assign domainReset = rstQ;
  assign domainOn    = onQ;
  assign busy        = busyQ;
  assign pwrError    = errQ;

endmodule
